// File: rtl/wb_select_unit.sv
`default_nettype none
// ============================================================================
// Module   : wb_select_unit
// Purpose  : Writeback source select with memory-ready wait, timeout and
//            illegal-select reporting; drives the register-file write port.
// Revision : 1.0 - initial release
// ============================================================================
module wb_select_unit #(
    parameter int DATA_W  = 8,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2,
    parameter int ADDR_W  = 3,
    parameter int MEM_SRC = 1,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [SEL_W-1:0]          src_sel,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [ADDR_W-1:0]         dest_addr,
    input  logic                      reg_write,
    input  logic                      mem_ready,
    output logic [DATA_W-1:0]         wb_data,
    output logic [ADDR_W-1:0]         wb_addr,
    output logic                      wb_en,
    output logic                      done,
    output logic                      busy,
    output logic [1:0]                err
);

    localparam logic [1:0] c_ERR_OK  = 2'b00;
    localparam logic [1:0] c_ERR_SEL = 2'b01;
    localparam logic [1:0] c_ERR_TMO = 2'b10;
    localparam logic [7:0] c_TMO_LIMIT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_WRITE    = 2'd2
    } state_t;

    state_t              r_state, w_state_next;
    logic [7:0]          r_wait_cnt, w_wait_cnt_next;
    logic                r_reg_write, w_reg_write_next;
    logic [ADDR_W-1:0]   r_dest, w_dest_next;
    logic [DATA_W-1:0]   w_data_next;
    logic [ADDR_W-1:0]   w_addr_next;
    logic [1:0]          w_err_next;
    logic                w_done_next;
    logic                w_wb_en_next;
    logic [DATA_W-1:0]   w_sel_data;
    logic [DATA_W-1:0]   w_mem_data;
    logic                w_sel_illegal;
    logic                w_sel_mem;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_sel == SEL_W'(i)) begin
                w_sel_data = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_mem_data    = src_data[MEM_SRC*DATA_W +: DATA_W];
    assign w_sel_illegal = 32'(src_sel) >= 32'(NUM_SRC);
    assign w_sel_mem     = (src_sel == SEL_W'(MEM_SRC));
    assign busy          = (r_state != S_IDLE);

    always_comb begin
        w_state_next     = r_state;
        w_wait_cnt_next  = r_wait_cnt;
        w_reg_write_next = r_reg_write;
        w_dest_next      = r_dest;
        w_data_next      = wb_data;
        w_err_next       = err;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_reg_write_next = reg_write;
                    w_dest_next      = dest_addr;
                    w_err_next       = c_ERR_OK;
                    if (w_sel_illegal) begin
                        w_err_next   = c_ERR_SEL;
                        w_state_next = S_WRITE;
                    end else if (w_sel_mem && !mem_ready) begin
                        w_wait_cnt_next = 8'd0;
                        w_state_next    = S_WAIT_MEM;
                    end else begin
                        w_data_next  = w_sel_data;
                        w_state_next = S_WRITE;
                    end
                end
            end
            S_WAIT_MEM: begin
                // mem_ready wins over a timeout landing in the same cycle
                if (mem_ready) begin
                    w_data_next  = w_mem_data;
                    w_state_next = S_WRITE;
                end else if (r_wait_cnt + 8'd1 == c_TMO_LIMIT) begin
                    w_wait_cnt_next = r_wait_cnt + 8'd1;
                    w_err_next      = c_ERR_TMO;
                    w_state_next    = S_WRITE;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 8'd1;
                end
            end
            S_WRITE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // Strobes are registered so they coincide exactly with the WRITE cycle
        w_done_next  = (w_state_next == S_WRITE);
        w_wb_en_next = w_done_next && w_reg_write_next && (w_err_next == c_ERR_OK);
        w_addr_next  = w_done_next ? w_dest_next : wb_addr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 8'd0;
            r_reg_write <= 1'b0;
            r_dest      <= '0;
            wb_data     <= '0;
            wb_addr     <= '0;
            wb_en       <= 1'b0;
            done        <= 1'b0;
            err         <= c_ERR_OK;
        end else begin
            r_state     <= w_state_next;
            r_wait_cnt  <= w_wait_cnt_next;
            r_reg_write <= w_reg_write_next;
            r_dest      <= w_dest_next;
            wb_data     <= w_data_next;
            wb_addr     <= w_addr_next;
            wb_en       <= w_wb_en_next;
            done        <= w_done_next;
            err         <= w_err_next;
        end
    end

endmodule
`default_nettype wire
